// File: rtl/argmax_sequencer.sv
// argmax_sequencer
//   Frames one classification: pulses the argmax unit's start, forwards
//   IN_SIZE signed scores to it one register deep, waits a bounded time for
//   its finish pulse, then holds the winning class index until downstream
//   takes it.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   frame_start   begins a frame (honoured only in IDLE)
//   score_valid   upstream score available
//   score_data    signed upstream score
//   score_ready   score accepted this cycle when score_valid is also high
//   am_start      one-cycle start pulse to the argmax unit
//   am_valid      data_valid to the argmax unit
//   am_data       class_in to the argmax unit
//   am_finish     finish pulse from the argmax unit
//   am_index      index_out from the argmax unit
//   result_valid  classified digit available
//   result_index  classified digit
//   result_ready  downstream accepts the result
//   busy          high in every state except IDLE
//   timeout_err   sticky: the last frame timed out waiting for am_finish
//   frame_count   completed-frame counter, wraps 255 -> 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in progress, waiting for frame_start
// ARM   | am_start pulsed for one cycle
// FEED  | forwarding scores until IN_SIZE have been accepted
// WAIT  | waiting for am_finish, bounded by TIMEOUT cycles
// DONE  | result_valid held until result_ready

module argmax_sequencer #(
  parameter int IN_SIZE    = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic                         score_valid,
  input  logic signed [DATA_WIDTH-1:0] score_data,
  output logic                         score_ready,
  output logic                         am_start,
  output logic                         am_valid,
  output logic signed [DATA_WIDTH-1:0] am_data,
  input  logic                         am_finish,
  input  logic [3:0]                   am_index,
  output logic                         result_valid,
  output logic [3:0]                   result_index,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [7:0]                   frame_count
);

  localparam int CNT_W  = $clog2(IN_SIZE + 1);
  // One spare count so the increment on the WAIT exit edge cannot overflow.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(IN_SIZE);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  score_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              finish_hit;
  logic              timeout_hit;

  assign accept      = score_valid & score_ready;
  // am_finish wins over the last timeout cycle.
  assign finish_hit  = (state == WAIT) & am_finish;
  assign timeout_hit = (state == WAIT) & ~am_finish & (wait_cnt == WAIT_LAST);

  // Outputs decode from the state register alone, so reset forces them low
  // without waiting for an edge.
  always_comb begin
    next_state   = state;
    am_start     = 1'b0;
    score_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (frame_start) next_state = ARM;
      end
      ARM: begin
        am_start   = 1'b1;
        next_state = FEED;
      end
      FEED: begin
        score_ready = (score_cnt < CNT_FULL);
        if (score_cnt == CNT_FULL) next_state = WAIT;
      end
      WAIT: begin
        if (finish_hit)       next_state = DONE;
        else if (timeout_hit) next_state = IDLE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Score counter: counts accepts in FEED, clears when the frame is full
  // (the WAIT entry edge) and whenever the FSM is outside FEED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_cnt <= '0;
    end else if (accept) begin
      score_cnt <= score_cnt + 1'b1;
    end else if ((state != FEED) || (score_cnt == CNT_FULL)) begin
      score_cnt <= '0;
    end
  end

  // Wait counter runs only in WAIT; it is zero on WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  // Single forwarding register: am_data holds between accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      am_valid <= 1'b0;
      am_data  <= '0;
    end else begin
      am_valid <= accept;
      if (accept) am_data <= score_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           result_index <= '0;
    else if (finish_hit) result_index <= am_index;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               timeout_err <= 1'b0;
    else if ((state == IDLE) && frame_start) timeout_err <= 1'b0;
    else if (timeout_hit)                    timeout_err <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               frame_count <= '0;
    else if ((state == DONE) && result_ready) frame_count <= frame_count + 1'b1;
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
// Bench for argmax_sequencer: a small behavioural argmax unit answers the
// DUT, a table of frames is run through it, and hand-written sequences cover
// timeout, backpressure, reset mid-feed and frame_count wrap.
module tb_argmax_sequencer;
  localparam int IN_SIZE = 10;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;

  typedef logic signed [DW-1:0] sc_t [IN_SIZE];
  typedef struct {
    sc_t        sc;
    bit         gapped;
    int         fin_delay;
    logic [3:0] exp_idx;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 frame_start = 1'b0;
  logic                 score_valid = 1'b0;
  logic signed [DW-1:0] score_data = '0;
  logic                 score_ready;
  logic                 am_start;
  logic                 am_valid;
  logic signed [DW-1:0] am_data;
  logic                 am_finish;
  logic [3:0]           am_index;
  logic                 result_valid;
  logic [3:0]           result_index;
  logic                 result_ready = 1'b0;
  logic                 busy;
  logic                 timeout_err;
  logic [7:0]           frame_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  // argmax unit model
  bit                   fin_en = 1'b1;
  int                   fin_delay = 3;
  bit                   force_fin = 1'b0;
  logic                 model_fin = 1'b0;
  logic [3:0]           model_idx = '0;
  int                   m_cnt = 0;
  int                   m_idx = 0;
  int                   fin_cd = 0;
  logic signed [DW-1:0] m_best = '0;
  int                   start_cnt = 0;
  int                   val_cnt = 0;
  logic signed [DW-1:0] cap [16];

  vec_t vecs [6];

  assign am_finish = model_fin | force_fin;
  assign am_index  = force_fin ? 4'd5 : model_idx;

  argmax_sequencer #(.IN_SIZE(IN_SIZE), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
    .am_start(am_start), .am_valid(am_valid), .am_data(am_data),
    .am_finish(am_finish), .am_index(am_index),
    .result_valid(result_valid), .result_index(result_index), .result_ready(result_ready),
    .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Model runs on the falling edge, where DUT outputs are stable.
  always @(negedge clk) begin
    model_fin = 1'b0;
    if (fin_cd > 0) begin
      fin_cd--;
      if (fin_cd == 0) begin
        model_fin = 1'b1;
        model_idx = 4'(m_idx);
      end
    end
    if (am_start) begin
      start_cnt++;
      m_cnt  = 0;
      m_idx  = 0;
      fin_cd = 0;
    end
    if (am_valid) begin
      if (val_cnt < 16) cap[val_cnt] = am_data;
      val_cnt++;
      if (m_cnt == 0 || am_data > m_best) begin
        m_best = am_data;
        m_idx  = m_cnt;
      end
      m_cnt++;
      if (m_cnt == IN_SIZE && fin_en) fin_cd = fin_delay;
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts a frame and feeds all IN_SIZE scores; returns on the falling edge
  // after the last accept.
  task automatic feed(input vec_t v, input bit pulse);
    int i;
    int k;
    i = 0;
    k = 0;
    start_cnt = 0;
    val_cnt   = 0;
    fin_delay = v.fin_delay;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    check("arm_pulse_busy", {30'b0, busy, am_start}, 2'b11);
    check("start_clears_err", {31'b0, timeout_err}, 0);
    while (i < IN_SIZE && k < 200) begin
      score_valid = v.gapped ? (k % 3 == 0) : 1'b1;
      score_data  = v.sc[i];
      frame_start = pulse && (k == 2);
      force_fin   = pulse && (k == 4);
      if (score_valid && score_ready) i++;
      step;
      k++;
    end
    frame_start = 1'b0;
    force_fin   = 1'b0;
    check("feed_budget", i, IN_SIZE);
    if (v.gapped) begin
      score_valid = 1'b1;
      score_data  = 16'sh7777;
      for (int j = 0; j < 3; j++) begin
        check("ready_low_after_full", {31'b0, score_ready}, 0);
        step;
      end
    end
    score_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int hold, input bit pulse);
    int g;
    int mism;
    feed(v, pulse);
    g = 0;
    while (!result_valid && g < 200) begin
      step;
      g++;
    end
    check("result_valid_rise", {31'b0, result_valid}, 1);
    check("result_index", {28'b0, result_index}, {28'b0, v.exp_idx});
    check("am_valid_pulses", val_cnt, IN_SIZE);
    mism = 0;
    for (int j = 0; j < IN_SIZE; j++) if (cap[j] !== v.sc[j]) mism++;
    check("fwd_values", mism, 0);
    result_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      frame_start = pulse && (h == 5);
      step;
      check("hold_stable", {27'b0, result_valid, result_index}, {27'b0, 1'b1, v.exp_idx});
    end
    frame_start  = 1'b0;
    result_ready = 1'b1;
    step;
    result_ready = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
    check("frame_count", {24'b0, frame_count}, exp_fc);
    check("back_to_idle", {30'b0, busy, result_valid}, 0);
    check("single_start", start_cnt, 1);
  endtask

  initial begin
    int i;
    int prev_fc;
    bit saw_rv;
    bit wrap_ok;

    vecs[0] = '{sc: '{16'sd5, -16'sd3, 16'sd7, 16'sd100, 16'sd2, 16'sd0, -16'sd8, 16'sd9, 16'sd1, 16'sd4},
                gapped: 1'b0, fin_delay: 3, exp_idx: 4'd3};
    vecs[1] = '{sc: '{16'sd5, -16'sd3, 16'sd7, 16'sd100, 16'sd2, 16'sd0, -16'sd8, 16'sd9, 16'sd1, 16'sd4},
                gapped: 1'b1, fin_delay: 1, exp_idx: 4'd3};
    vecs[2] = '{sc: '{-16'sd100, -16'sd50, -16'sd7, -16'sd9, -16'sd30, -16'sd2000, -16'sd8, -16'sd40, -16'sd6, -16'sd300},
                gapped: 1'b0, fin_delay: 5, exp_idx: 4'd8};
    vecs[3] = '{sc: '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1},
                gapped: 1'b1, fin_delay: 2, exp_idx: 4'd9};
    vecs[4] = '{sc: '{16'sh7fff, 16'sh8000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                gapped: 1'b0, fin_delay: 1, exp_idx: 4'd0};
    vecs[5] = '{sc: '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd60, 16'sd70, 16'sd80, 16'sd90, -16'sd1},
                gapped: 1'b0, fin_delay: 4, exp_idx: 4'd8};

    // reset state
    step;
    step;
    check("rst_flags", {26'b0, score_ready, am_start, am_valid, result_valid, busy, timeout_err}, 0);
    check("rst_am_data", {16'b0, am_data}, 0);
    check("rst_idx_count", {20'b0, result_index, frame_count}, 0);
    reset = 1'b0;

    // am_finish in IDLE is ignored
    force_fin = 1'b1;
    step;
    force_fin = 1'b0;
    check("finish_ignored_idle", {28'b0, busy, result_valid, result_index}, 0);

    // table of frames
    for (int n = 0; n < 6; n++) run_frame(vecs[n], (n == 0) ? 2 : 0, 1'b0);

    // timeout: no am_finish after the 10th score
    fin_en = 1'b0;
    feed(vecs[0], 1'b0);
    saw_rv = 1'b0;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      step;
      if (result_valid) saw_rv = 1'b1;
      if (k == TIMEOUT)     check("timeout_not_yet", {30'b0, timeout_err, busy}, 2'b01);
      if (k == TIMEOUT + 1) check("timeout_set_idle", {30'b0, timeout_err, busy}, 2'b10);
    end
    check("timeout_no_result", {31'b0, saw_rv}, 0);
    check("timeout_fc_hold", {24'b0, frame_count}, exp_fc);
    fin_en = 1'b1;

    // backpressure with ignored frame_start/am_finish; also clears timeout_err
    run_frame(vecs[0], 20, 1'b1);

    // reset after the 4th score
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    i = 0;
    for (int k = 0; k < 50 && i < 4; k++) begin
      score_valid = 1'b1;
      score_data  = vecs[0].sc[i];
      if (score_ready) i++;
      step;
    end
    score_valid = 1'b0;
    check("pre_reset_fed", {31'b0, am_valid}, 1);
    reset = 1'b1;
    #1;
    check("midrst_flags", {26'b0, score_ready, am_start, am_valid, result_valid, busy, timeout_err}, 0);
    check("midrst_am_data", {16'b0, am_data}, 0);
    check("midrst_idx_count", {20'b0, result_index, frame_count}, 0);
    step;
    reset = 1'b0;
    exp_fc = 0;
    run_frame(vecs[2], 0, 1'b0);

    // 256 frames: frame_count must wrap 255 -> 0
    wrap_ok = 1'b0;
    for (int f = 0; f < 256; f++) begin
      prev_fc = int'(frame_count);
      run_frame(vecs[f % 6], 0, 1'b0);
      if (prev_fc == 255 && frame_count == 8'd0) wrap_ok = 1'b1;
    end
    check("wrap_seen", {31'b0, wrap_ok}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/argmax_sequencer.md
ARGMAX_SEQUENCER -- requirements
Module: argmax_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- IN_SIZE, default 10, number of class scores per frame (2..15).
- DATA_WIDTH, default 16, signed score width.
- TIMEOUT, default 64, maximum cycles to wait for argmax completion.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  pulse that begins one classification frame.
- score_valid  in  1  upstream score available.
- score_data  in  DATA_WIDTH  signed upstream score.
- score_ready  out  1  block accepts a score this cycle.
- am_start  out  1  start pulse to the argmax unit.
- am_valid  out  1  data_valid to the argmax unit.
- am_data  out  DATA_WIDTH  class_in to the argmax unit.
- am_finish  in  1  finish pulse from the argmax unit.
- am_index  in  4  index_out from the argmax unit.
- result_valid  out  1  classified digit available.
- result_index  out  4  classified digit.
- result_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag: last frame timed out.
- frame_count  out  8  completed-frame counter.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, ARM, FEED, WAIT, DONE.
REQ-004 In IDLE, frame_start=1 at an edge SHALL move the FSM to ARM and clear timeout_err.
REQ-005 frame_start SHALL be ignored in every state other than IDLE.
REQ-006 In ARM, am_start SHALL be 1 for exactly one cycle; the FSM SHALL then move to FEED unconditionally.
REQ-007 am_start SHALL be 0 in every state other than ARM.
REQ-008 In FEED, score_ready SHALL equal (score_cnt < IN_SIZE), decoded combinationally from state and counter.
REQ-009 score_ready SHALL be 0 in every state other than FEED.
REQ-010 On each edge with score_valid and score_ready both high:
- am_data SHALL register score_data.
- am_valid SHALL be 1 for the following cycle.
- score_cnt SHALL increment by 1.
REQ-011 On any edge without an accepted score, am_valid SHALL be 0; am_data SHALL hold its value.
REQ-012 Scores SHALL be forwarded unmodified, in arrival order; no buffering beyond one register.
REQ-013 When score_cnt reaches IN_SIZE, the FSM SHALL enter WAIT on the next edge, with score_cnt and the wait counter cleared.
REQ-014 In WAIT, the wait counter SHALL increment each cycle.
REQ-015 In WAIT, am_finish=1 SHALL register am_index into result_index and move the FSM to DONE.
REQ-016 If am_finish and wait counter = TIMEOUT-1 occur on the same edge, am_finish SHALL take priority.
REQ-017 In WAIT, if the wait counter reaches TIMEOUT-1 without am_finish:
- timeout_err SHALL be set.
- The FSM SHALL return to IDLE.
- result_valid SHALL not be asserted.
- frame_count SHALL be unchanged.
REQ-018 am_finish seen outside WAIT SHALL be ignored.
REQ-019 In DONE, result_valid SHALL be 1 and result_index SHALL be stable until result_ready=1.
REQ-020 On the DONE edge with result_ready=1:
- frame_count SHALL increment, wrapping 255 to 0.
- The FSM SHALL return to IDLE.
REQ-021 result_ready SHALL be ignored outside DONE.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 Latency SHALL be:
- frame_start edge to am_start high: 1 cycle.
- Accepted score to am_valid: 1 cycle.
- am_finish edge to result_valid: 1 cycle.

Reset
REQ-024 While reset is high, the block SHALL immediately, without waiting for a clock edge:
- Enter IDLE.
- Drive am_start, am_valid, score_ready, result_valid, busy and timeout_err to 0.
- Drive am_data, result_index, frame_count, score_cnt and the wait counter to 0.
REQ-025 Reset asserted mid-frame, in any state, SHALL abandon the frame with no result and no frame_count change.
REQ-026 After reset deasserts, the block SHALL accept frame_start on the first edge.

Verification
REQ-027 Nominal frame:
- Stimulus: frame_start, then scores 5,-3,7,100,2,0,-8,9,1,4 back-to-back, with an argmax model attached.
- Response: am_start high one cycle; 10 am_valid pulses carrying the same values in order; result_index=3; result_valid until result_ready; frame_count=1.
REQ-028 Gapped input:
- Stimulus: score_valid toggled 1,0,0,1,... across the frame; score_valid held high after the 10th score.
- Response: exactly 10 am_valid pulses; score_ready=0 after the 10th accept; no 11th score consumed.
REQ-029 Timeout:
- Stimulus: am_finish never asserted after the 10th score.
- Response: timeout_err=1 exactly TIMEOUT cycles after WAIT entry; FSM in IDLE; result_valid never 1; next frame_start clears timeout_err.
REQ-030 Backpressure and ignored start:
- Stimulus: result_ready held 0 for 20 cycles; frame_start pulsed during FEED and during DONE.
- Response: result_valid and result_index stable for all 20 cycles; no restart; frame_count increments once.
REQ-031 Reset mid-feed:
- Stimulus: reset pulsed after the 4th score.
- Response: all outputs 0 immediately; a following full frame classifies correctly; frame_count=1.
REQ-032 Counter wrap:
- Stimulus: 256 consecutive completed frames.
- Response: frame_count wraps from 255 to 0.
